// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Turns the PLL lock flag and the board reset into ordered, synchronously
//   released resets: memory/peripheral reset first, then core reset plus a
//   ready flag. Any loss of lock pulls both resets back in on one edge, and
//   losses that happen while running are recorded for diagnostics.
//
// Ports
//   clk            PLL output clock (2 MHz, 0 deg)
//   rst            asynchronous, active-high reset
//   pll_locked     PLL lock flag, asynchronous to clk
//   lost_clr       synchronous pulse, clears lock_lost
//   mem_rst        active-high reset to memory/peripherals
//   core_rst       active-high reset to the core
//   ready          high only while running
//   lock_lost      sticky flag: lock dropped while running
//   lock_loss_cnt  saturating count of lock drops while running
module pll_reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int MEM_CYCLES    = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             lost_clr,
    output logic             mem_rst,
    output logic             core_rst,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    // One shared sequence counter covers both the stable and memory windows.
    localparam int SEQ_MAX = (STABLE_CYCLES > MEM_CYCLES) ? STABLE_CYCLES : MEM_CYCLES;
    localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_MEM_REL,
        S_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [SEQ_W-1:0]       seq_cnt_q, seq_cnt_d;
    logic [1:0]             rst_sync_q, rst_sync_d;
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic                   mem_rst_q, mem_rst_d;
    logic                   core_rst_q, core_rst_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0]       loss_cnt_q, loss_cnt_d;

    logic rst_hold;
    logic locked_s;
    logic run_loss;

    // Reset assertion is asynchronous; release ripples through two flops so
    // the sequencer leaves RESET cleanly on a clock edge.
    assign rst_hold = rst_sync_q[1];
    assign locked_s = lock_sync_q[SYNC_STAGES-1];

    always_comb begin
        rst_sync_d  = {rst_sync_q[0], 1'b0};
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};

        state_d   = state_q;
        seq_cnt_d = seq_cnt_q;
        run_loss  = 1'b0;

        case (state_q)
            S_RESET: state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d   = S_STABLE;
                    seq_cnt_d = '0;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (seq_cnt_q == SEQ_W'(STABLE_CYCLES - 1)) begin
                    state_d   = S_MEM_REL;
                    seq_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end
            S_MEM_REL: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (seq_cnt_q == SEQ_W'(MEM_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d  = S_WAIT_LOCK;
                    run_loss = 1'b1;
                end
            end
            default: state_d = S_RESET;
        endcase

        if (rst_hold) begin
            state_d   = S_RESET;
            seq_cnt_d = '0;
            run_loss  = 1'b0;
        end

        // A loss on the same edge as a clear request wins.
        lock_lost_d = lock_lost_q;
        if (run_loss)
            lock_lost_d = 1'b1;
        else if (lost_clr)
            lock_lost_d = 1'b0;

        loss_cnt_d = loss_cnt_q;
        if (run_loss && (loss_cnt_q != {CNT_W{1'b1}}))
            loss_cnt_d = loss_cnt_q + CNT_W'(1);

        // Outputs are the decode of the next state so they move on the same
        // edge as the transition and come straight from flops.
        mem_rst_d  = !((state_d == S_MEM_REL) || (state_d == S_RUN));
        core_rst_d = (state_d != S_RUN);
        ready_d    = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync_q  <= 2'b11;
            lock_sync_q <= '0;
            state_q     <= S_RESET;
            seq_cnt_q   <= '0;
            mem_rst_q   <= 1'b1;
            core_rst_q  <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            rst_sync_q  <= rst_sync_d;
            lock_sync_q <= lock_sync_d;
            state_q     <= state_d;
            seq_cnt_q   <= seq_cnt_d;
            mem_rst_q   <= mem_rst_d;
            core_rst_q  <= core_rst_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

    assign mem_rst       = mem_rst_q;
    assign core_rst      = core_rst_q;
    assign ready         = ready_q;
    assign lock_lost     = lock_lost_q;
    assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Sits directly downstream of the 2 MHz system PLL wrapper and runs on its 0° output clock. It consumes the PLL `locked` flag and the board reset, then produces ordered, synchronously-deasserted resets: memory/peripheral reset first, then core reset and a `ready` flag. It also re-asserts both resets whenever lock is lost, and keeps lock-loss diagnostics.

Parameters:
SYNC_STAGES, 2, flops in the `pll_locked` synchroniser (minimum 2).
STABLE_CYCLES, 16, consecutive synchronised-lock cycles required before any reset is released (minimum 1).
MEM_CYCLES, 4, cycles between `mem_rst` release and `core_rst` release (minimum 1).
CNT_W, 8, width of the saturating lock-loss counter.

Ports:
clk  in  1  PLL outclk_0 (2 MHz, 0° phase)
rst  in  1  asynchronous, active-high reset
pll_locked  in  1  PLL lock flag, asynchronous to clk
lost_clr  in  1  synchronous pulse; clears `lock_lost`
mem_rst  out  1  active-high reset to memory/peripherals
core_rst  out  1  active-high reset to the MIPS core
ready  out  1  high only in RUN
lock_lost  out  1  sticky: lock dropped while in RUN
lock_loss_cnt  out  CNT_W  saturating count of RUN lock drops

Behaviour:
- Reset is asynchronous and active-high. While `rst`=1: state=RESET, synchroniser flops=0, internal counter=0. Outputs: `mem_rst`=1, `core_rst`=1, `ready`=0, `lock_lost`=0, `lock_loss_cnt`=0.
- `rst` deassertion is synchronised internally (2-flop release). Outputs change only on clk edges after release.
- `pll_locked` passes through a SYNC_STAGES synchroniser; `locked_s` is the last stage. All decisions use `locked_s` only.
- All outputs are flops, loaded with the decode of the next state. They change on the same edge as the state transition and are glitch-free.
- States and transitions:
  - RESET: next edge -> WAIT_LOCK.
  - WAIT_LOCK: mem_rst=1, core_rst=1. If `locked_s`=1 -> STABLE with cnt=0.
  - STABLE: mem_rst=1, core_rst=1.
    - If `locked_s`=0 -> WAIT_LOCK.
    - Else if cnt==STABLE_CYCLES-1 -> MEM_REL with cnt=0.
    - Else cnt++.
  - MEM_REL: mem_rst=0, core_rst=1.
    - If `locked_s`=0 -> WAIT_LOCK.
    - Else if cnt==MEM_CYCLES-1 -> RUN.
    - Else cnt++.
  - RUN: mem_rst=0, core_rst=0, ready=1. If `locked_s`=0 -> WAIT_LOCK.
- Timing with defaults: `pll_locked` first sampled high at edge E0 gives `mem_rst` low after edge E18 (SYNC_STAGES+STABLE_CYCLES) and `core_rst`/`ready` change after edge E22 (+MEM_CYCLES).
- Lock loss:
  - On any exit to WAIT_LOCK, both resets assert and `ready` drops on that same edge.
  - A lock glitch shorter than one sample period that is never captured by the synchroniser has no effect.
- Lock loss from RUN only:
  - `lock_lost` is set.
  - `lock_loss_cnt` increments and saturates at 2^CNT_W-1 (no wrap).
  - Loss from STABLE/MEM_REL only restarts the sequence and does not count.
- `lost_clr`: clears `lock_lost` next edge. Does not clear `lock_loss_cnt`. If a RUN loss occurs on the same edge, set wins.
- `rst` asserted mid-sequence or in RUN: immediate asynchronous return to reset values. `lock_lost` and `lock_loss_cnt` are also cleared.
- `mem_rst`=0 is never observed while `core_rst`=0 is not yet reached out of order: `core_rst` never deasserts while `mem_rst`=1.

Test Plan:
- Power-up: `rst`=1 for 5 cycles, `pll_locked`=0 -> all outputs at reset values. After release with `pll_locked`=0 for 100 cycles, both resets stay 1.
- Clean lock: `pll_locked` rises and is sampled at E0 -> `mem_rst` falls after E18, `core_rst`=0 and `ready`=1 after E22, and they stay there for 200 cycles.
- Lock drops during STABLE at cycle 10 for 3 cycles -> count restarts. `mem_rst` falls 18 cycles after re-lock sampling, and `lock_loss_cnt` stays 0.
- Lock drops in RUN -> within SYNC_STAGES+1 edges `core_rst`=1, `mem_rst`=1, `ready`=0, `lock_lost`=1, cnt=1. Re-lock resequences to RUN in 22 cycles.
- CNT_W=2, 5 RUN losses -> `lock_loss_cnt` reads 1,2,3,3,3. `lost_clr` pulsed on the same edge as the 5th loss -> `lock_lost` remains 1.
- `rst` pulse asserted asynchronously while in MEM_REL -> `mem_rst`=1 immediately (before the next edge), counters=0, full sequence repeats.
